// File: rtl/avl_sample_fifo_pkg.sv
// Shared definitions for the Avalon-MM audio sample FIFO slave:
// register word offsets, CONTROL/STATUS bit positions and the read FSM state type.
package avl_sample_fifo_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    // CONTROL keeps only its three stored bits; CLEAR is a write-only strobe.
    localparam int CTRL_W      = 3;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_BLOCK  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLEAR  = 31;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_IRQ   = 19;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_ACK  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sample_fifo_sync.sv
// Single-clock show-ahead FIFO of 32-bit words.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   push/push_data  - enqueue one word (ignored when full)
//   pop             - dequeue the head word (ignored when empty)
//   flush           - empty the FIFO; overrides push and pop in the same cycle
//   head_data       - current head word (valid while !empty)
//   level           - number of stored words, 0..DEPTH
//   full, empty     - decoded from the registered level
module sample_fifo_sync #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [31:0]      head_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            // Push and pop together leave the level unchanged.
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/avl_mm_slave_sample_fifo.sv
// Avalon-MM slave buffering audio samples into a FIFO and streaming them out.
// Ports:
//   clk, reset                    - clock, synchronous active-low reset
//   avs_address/read/write/...    - Avalon-MM slave: 0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD
//   avs_readdata, avs_waitrequest - read data (2-cycle latency) and stall
//   irq                           - level refill interrupt (registered)
//   st_data/st_valid/st_ready     - show-ahead sample stream toward the audio path
//
// Read FSM:
//   state   | meaning
//   RD_IDLE | no read in flight; a read stalls one cycle and captures readdata
//   RD_ACK  | readdata valid, waitrequest low; back to RD_IDLE next cycle
module avl_mm_slave_sample_fifo
    import avl_sample_fifo_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        irq,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [LVL_W-1:0]  thresh_q, thresh_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
    rd_state_t         rd_state_q, rd_state_d;

    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full, fifo_empty;
    logic              fifo_push, fifo_pop, fifo_flush;

    logic wr_data, wr_status, wr_ctrl, wr_thresh;
    logic wr_blocked, ovf_set, rd_req;
    logic [31:0] status_word, rd_mux;

    assign wr_data   = avs_write && (avs_address == ADDR_DATA);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_thresh = avs_write && (avs_address == ADDR_THRESH);

    // fifo_full comes from the registered level, so a pop in this cycle only
    // releases a blocked write on the following cycle.
    assign wr_blocked = wr_data && fifo_full && ctrl_q[CTRL_BLOCK];
    assign ovf_set    = wr_data && fifo_full && !ctrl_q[CTRL_BLOCK];
    assign fifo_push  = wr_data && !fifo_full;
    assign fifo_flush = wr_ctrl && avs_writedata[CTRL_CLEAR];

    assign st_valid = ctrl_q[CTRL_ENABLE] && !fifo_empty;
    assign fifo_pop = st_valid && st_ready;

    // A read issued together with a write is dropped; the write wins.
    assign rd_req = avs_read && !avs_write && (rd_state_q == RD_IDLE);

    assign avs_waitrequest = wr_blocked || rd_req;
    assign avs_readdata    = rdata_q;
    assign irq             = irq_q;

    sample_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (avs_writedata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (st_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        status_word               = '0;
        status_word[LVL_W-1:0]    = fifo_level;
        status_word[ST_EMPTY]     = fifo_empty;
        status_word[ST_FULL]      = fifo_full;
        status_word[ST_OVF]       = ovf_q;
        status_word[ST_IRQ]       = irq_q;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_STATUS: rd_mux = status_word;
            ADDR_CTRL:   rd_mux = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_THRESH: rd_mux = {{(32-LVL_W){1'b0}}, thresh_q};
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        thresh_d   = thresh_q;
        ovf_d      = ovf_q;
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        irq_d      = ctrl_q[CTRL_IRQ_EN] && (fifo_level <= thresh_q);

        if (wr_status && avs_writedata[ST_OVF]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (wr_ctrl) begin
            ctrl_d = avs_writedata[CTRL_W-1:0];
            if (avs_writedata[CTRL_CLEAR]) ovf_d = 1'b0;
        end
        if (wr_thresh) thresh_d = avs_writedata[LVL_W-1:0];

        case (rd_state_q)
            RD_IDLE: begin
                if (rd_req) begin
                    rd_state_d = RD_ACK;
                    rdata_d    = rd_mux;
                end
            end
            RD_ACK:  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q     <= '0;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rd_state_q <= RD_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            thresh_q   <= thresh_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rd_state_q <= rd_state_d;
        end
    end

endmodule

// File: tb/tb_avl_mm_slave_sample_fifo.sv
module tb_avl_mm_slave_sample_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        irq;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [2:0]  ctrl_m = '0;
    logic [6:0]  thresh_m = '0;
    logic        ovf_m = 1'b0;
    logic        irq_m = 1'b0;
    logic        rdack_m = 1'b0;
    logic [31:0] rdata_m = '0;
    logic        wait_m = 1'b0;
    logic        obs_wait = 1'b0;

    always #5 clk = ~clk;

    avl_mm_slave_sample_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .irq             (irq),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model for the current cycle,
    // then advance the model by the rules of the register map and FIFO.
    task automatic step();
        int          lvl;
        logic        full_m, pop, push, flush, exp_valid;
        logic [31:0] sw, wd;
        logic [2:0]  n_ctrl;
        logic [6:0]  n_thresh;
        logic        n_ovf, n_irq, n_rdack;
        logic [31:0] n_rdata;

        #1;
        lvl       = q.size();
        full_m    = (lvl == DEPTH);
        exp_valid = ctrl_m[0] && (lvl > 0);
        wait_m    = (avs_write && avs_address == 2'd0 && full_m && ctrl_m[1]) ||
                    (!avs_write && avs_read && !rdack_m);
        obs_wait  = avs_waitrequest;

        chk("waitrequest", {31'b0, avs_waitrequest}, {31'b0, wait_m});
        chk("st_valid", {31'b0, st_valid}, {31'b0, exp_valid});
        if (exp_valid) chk("st_data", st_data, q[0]);
        chk("irq", {31'b0, irq}, {31'b0, irq_m});
        chk("readdata", avs_readdata, rdata_m);

        sw = 32'(lvl);
        sw[16] = (lvl == 0);
        sw[17] = full_m;
        sw[18] = ovf_m;
        sw[19] = irq_m;

        wd       = avs_writedata;
        n_ctrl   = ctrl_m;
        n_thresh = thresh_m;
        n_ovf    = ovf_m;
        n_irq    = ctrl_m[2] && (lvl <= int'(thresh_m));
        n_rdack  = 1'b0;
        n_rdata  = rdata_m;
        pop      = exp_valid && st_ready;
        push     = 1'b0;
        flush    = 1'b0;

        if (!avs_write && avs_read && !rdack_m) begin
            n_rdack = 1'b1;
            case (avs_address)
                2'd1:    n_rdata = sw;
                2'd2:    n_rdata = {29'b0, ctrl_m};
                2'd3:    n_rdata = {25'b0, thresh_m};
                default: n_rdata = 32'h0;
            endcase
        end
        if (avs_write) begin
            case (avs_address)
                2'd0: begin
                    if (!full_m) push = 1'b1;
                    else if (!ctrl_m[1]) n_ovf = 1'b1;
                end
                2'd1: if (wd[18]) n_ovf = 1'b0;
                2'd2: begin
                    n_ctrl = wd[2:0];
                    if (wd[31]) begin
                        flush = 1'b1;
                        n_ovf = 1'b0;
                    end
                end
                default: n_thresh = wd[6:0];
            endcase
        end
        if (!reset) begin
            flush = 1'b1; n_ctrl = '0; n_thresh = '0; n_ovf = 1'b0;
            n_irq = 1'b0; n_rdack = 1'b0; n_rdata = '0;
        end

        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(wd);
        end
        ctrl_m = n_ctrl; thresh_m = n_thresh; ovf_m = n_ovf;
        irq_m = n_irq; rdack_m = n_rdack; rdata_m = n_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        do begin
            step();
            n++;
        end while (wait_m && n < 200);
        if (n >= 200) chk("wr_timeout", {31'b0, wait_m}, 32'h0);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = a;
        step();
        d = avs_readdata;
        step();
        avs_read = 1'b0;
    endtask

    initial begin
        logic [31:0] d;

        @(posedge clk);
        #1;
        // Reset and empty STATUS readback
        step(); step();
        reset = 1'b1;
        step();
        rd(2'd1, d);
        chk("rst_status", d, 32'h0001_0000);

        // Three samples, then drain in order
        wr(2'd2, 32'h1);
        wr(2'd0, 32'hA1); wr(2'd0, 32'hB2); wr(2'd0, 32'hC3);
        rd(2'd1, d);
        chk("lvl3_status", d, 32'h0000_0003);
        chk("head_a1", st_data, 32'hA1);
        st_ready = 1'b1;
        chk("drain0", st_data, 32'hA1); step();
        chk("drain1", st_data, 32'hB2); step();
        chk("drain2", st_data, 32'hC3); step();
        chk("drain_end", {31'b0, st_valid}, 32'h0);
        st_ready = 1'b0;

        // Overflow with BLOCK=0
        for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, 32'h1000 + i);
        rd(2'd1, d);
        chk("ovf_status", d, 32'h0006_0040);
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, d);
        chk("ovf_clr_status", d, 32'h0002_0040);

        // Blocked write released one cycle after a pop
        wr(2'd2, 32'h3);
        avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'hDEAD_BEEF;
        step(); step(); step();
        chk("blk_hold", {31'b0, obs_wait}, 32'h1);
        st_ready = 1'b1;
        step();
        chk("blk_pop_cycle", {31'b0, obs_wait}, 32'h1);
        st_ready = 1'b0;
        step();
        chk("blk_accept", {31'b0, obs_wait}, 32'h0);
        avs_write = 1'b0;
        rd(2'd1, d);
        chk("blk_status", d, 32'h0002_0040);

        // Watermark interrupt and CLEAR
        wr(2'd2, 32'h8000_0001);
        wr(2'd3, 32'hFFFF_FF82);
        rd(2'd3, d);
        chk("thresh_rb", d, 32'h0000_0002);
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h2000 + i);
        wr(2'd2, 32'h7);
        step();
        chk("irq_lvl4", {31'b0, irq}, 32'h0);
        st_ready = 1'b1;
        step(); step();
        st_ready = 1'b0;
        chk("irq_pre", {31'b0, irq}, 32'h0);
        step();
        chk("irq_rise", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h8000_0007);
        rd(2'd1, d);
        chk("clr_status", d, 32'h0009_0000);
        rd(2'd2, d);
        chk("ctrl_rb", d, 32'h0000_0007);

        // Reset during a blocked write
        for (int i = 0; i < DEPTH; i++) wr(2'd0, 32'h3000 + i);
        avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'h55;
        step();
        chk("rst_blk_hold", {31'b0, obs_wait}, 32'h1);
        reset = 1'b0;
        step();
        reset = 1'b1; avs_write = 1'b0;
        step();
        chk("rst_blk_wait", {31'b0, obs_wait}, 32'h0);
        rd(2'd1, d);
        chk("rst_blk_status", d, 32'h0001_0000);

        // Reset while in RD_ACK
        avs_read = 1'b1; avs_address = 2'd1;
        step();
        reset = 1'b0; avs_read = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rst_ack_wait", {31'b0, obs_wait}, 32'h0);
        chk("rst_ack_rdata", avs_readdata, 32'h0);

        // Randomized traffic
        wr(2'd2, 32'h1);
        wait_m = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (!wait_m) begin
                r = int'($urandom_range(0, 99));
                avs_write = (r < 40);
                avs_read  = (r >= 35 && r < 60);
                avs_address = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
                avs_writedata = $urandom;
                if (avs_write && avs_address == 2'd2) begin
                    avs_writedata[31] = ($urandom_range(0, 15) == 0);
                    avs_writedata[0]  = ($urandom_range(0, 3) != 0) || avs_writedata[1];
                end
            end
            if (i < 2000) st_ready = ($urandom_range(0, 3) == 0);
            else          st_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        avs_write = 1'b0; avs_read = 1'b0; st_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avl_mm_slave_sample_fifo.md
Name: avl_mm_slave_sample_fifo

Overview:
Avalon-MM slave (responder) that receives audio samples written by a CPU/DMA master and buffers them in a FIFO. It exposes the buffered samples on a valid/ready stream toward the audio output path. Control, status and watermark registers are mapped alongside the data port. An interrupt requests a refill when the fill level drops to the programmed watermark.

Parameters:
DEPTH, 64, FIFO depth in 32-bit words; power of two, minimum 4.
LVL_W, $clog2(DEPTH)+1, width of the fill-level count; derived, not overridden.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset; sampled on clk rising edge
avs_address  in  2  word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data; valid when avs_read=1 and avs_waitrequest=0
avs_waitrequest  out  1  stall to master
irq  out  1  level-sensitive refill interrupt
st_data  out  32  FIFO head sample
st_valid  out  1  st_data valid
st_ready  in  1  sink accepts st_data

Behaviour:
- Reset (reset=0 at clk edge):
  - FIFO is emptied.
  - CONTROL=0, THRESHOLD=0, OVERFLOW=0.
  - avs_readdata=0, avs_waitrequest=0, irq=0, st_valid=0.
  - FSM goes to IDLE; any in-flight read is abandoned.
- CONTROL bits:
  - [0] ENABLE
  - [1] BLOCK
  - [2] IRQ_EN
  - [31] CLEAR: write-1, self-clearing. Flushes the FIFO to level 0 and clears OVERFLOW in the same edge. Always reads 0.
  - Other bits read 0.
- STATUS (read-only except OVERFLOW):
  - [LVL_W-1:0] level
  - [16] EMPTY
  - [17] FULL
  - [18] OVERFLOW: sticky; cleared by writing 1 to bit 18.
  - [19] irq
- THRESHOLD: [LVL_W-1:0] are writable; upper bits are ignored on write and read as 0.
- Write to DATA:
  - Not full: push, zero wait states (avs_waitrequest=0 in that cycle).
  - Full and BLOCK=0: data dropped, OVERFLOW set, no wait state.
  - Full and BLOCK=1: avs_waitrequest=1 while full. The write is accepted in the first cycle in which full=0 at cycle start; the master holds its signals.
- Full/empty are evaluated from the registered level at cycle start.
  - A pop in the same cycle as a blocked write does not release that write until the next cycle.
- Stream side:
  - st_valid = ENABLE && !EMPTY.
  - st_data = head word (show-ahead).
  - A pop occurs when st_valid && st_ready.
  - ENABLE=0 holds the FIFO contents.
- Simultaneous push and pop with level strictly between 0 and DEPTH: level unchanged, data order preserved.
- Push into an empty FIFO: st_valid rises the next cycle.
- Level arithmetic:
  - 0..DEPTH in LVL_W bits.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Level never over- or underflows.
- Read FSM:
  - IDLE: avs_read=1 → avs_waitrequest=1 that cycle; register the selected readdata; go to RD_ACK.
  - RD_ACK: avs_waitrequest=0, avs_readdata valid; return to IDLE next cycle.
  - Read latency is 2 cycles.
  - Reads of DATA return 0 and never pop.
  - avs_readdata holds its last value between reads.
- avs_read and avs_write asserted together is a protocol violation: the write is performed and the read is ignored.
- A CLEAR coinciding with a stream pop: CLEAR wins, level=0.
- irq is registered: irq = IRQ_EN && (level <= THRESHOLD), updated one cycle after the level or register change.

Decomposition:
- Package avl_sample_fifo_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_THRESH=3;
  - CONTROL bit indices CTRL_ENABLE=0, CTRL_BLOCK=1, CTRL_IRQ_EN=2, CTRL_CLEAR=31;
  - STATUS bit indices ST_EMPTY=16, ST_FULL=17, ST_OVF=18, ST_IRQ=19;
  - the read FSM state enum.
- Sub-module sample_fifo_sync is a single-clock show-ahead FIFO providing push, pop, flush, level, full, empty, parameterised on DEPTH. The top level holds the Avalon decode, registers, FSM and irq.

Test Plan:
- Reset, then read STATUS → waitrequest=1 for 1 cycle, then readdata=0x0001_0000 (EMPTY=1, level 0); irq=0, st_valid=0.
- CONTROL=1; write 0xA1, 0xB2, 0xC3 to DATA with st_ready=0 → STATUS level=3, st_data=0xA1. Then st_ready=1 → 0xA1, 0xB2, 0xC3 on consecutive cycles, then st_valid=0.
- DEPTH=64, BLOCK=0: 65 writes → level=64, FULL=1, OVERFLOW=1, 65th word absent from the stream. Write 0x0004_0000 to STATUS → OVERFLOW=0.
- BLOCK=1, FIFO full, one more write → waitrequest held high. Pulse st_ready for 1 cycle → write accepted the cycle after the pop, level back to 64.
- THRESHOLD=2, IRQ_EN=1, level 4: drain 2 words → irq rises 1 cycle after level reaches 2. Write CONTROL CLEAR → level 0, irq stays 1, CONTROL readback = 0x7 without bit 31.
- Pull reset low in the middle of a blocked write and in RD_ACK → next cycle waitrequest=0, level=0, FSM in IDLE.
